seq_shifter: RTL and testbench
==============================

# seq_shifter

Parametrised multi-mode sequential shifter: captures a WIDTH-bit operand, then shifts it one bit position per clock by a requested amount in one of four modes (logical right, logical left, arithmetic right, rotate right). It reports the last bit shifted out and signals completion with a start/busy/done handshake. It replaces the fixed 16-bit, shift-by-one combinational shifter in the datapath wherever variable shift amounts and modes are needed.

## Interface
- WIDTH, 16, operand/result width; must be ≥ 2.
- AMT_W, $clog2(WIDTH)+1, width of amount; fixed by derivation, not overridden.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear; overrides start.
- start  input  1  request; accepted only when not busy.
- in  input  WIDTH  operand, sampled on the accepting edge.
- amount  input  AMT_W  shift count, sampled with in.
- mode  input  2  00 LSR, 01 LSL, 10 ASR, 11 ROR; sampled with in.
- out  output  WIDTH  working/result register.
- carry  output  1  last bit shifted out.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when result is final.

## Operation
- States: IDLE, SHIFT, DONE. busy = (state == SHIFT). done = (state == DONE).
- Accept: start high in IDLE or DONE. On the accepting edge: out <= in, mode register <= mode, cnt <= min(amount, WIDTH), carry <= 0. Next state is DONE if the clamped count is 0, otherwise SHIFT.
- SHIFT edge: out <= step(out, mode); carry <= the bit that leaves the word; cnt <= cnt-1. If cnt == 1, next state is DONE.
- Step rules:
  - LSR: zero fill at MSB, carry = bit 0.
  - LSL: zero fill at LSB, carry = bit WIDTH-1.
  - ASR: MSB replicated, carry = bit 0.
  - ROR: bit 0 moves to MSB, carry = bit 0.
- Clamping: amount > WIDTH is treated as WIDTH. LSR/LSL by WIDTH give 0; ASR by WIDTH gives all copies of the sign; ROR by WIDTH returns the operand unchanged.
- DONE: lasts exactly one cycle. Then state goes to IDLE, unless start is accepted on that edge.
- out and carry hold after DONE until the next accepted start or clear.
- start while busy: ignored; no queuing.
- clear, synchronous: state IDLE, out 0, carry 0, cnt 0. No done pulse is produced, even mid-shift or when simultaneous with start.
- reset, asynchronous: same values as clear, applied immediately. Any shift in progress is abandoned.

## Timing
- Reset values: out 0, carry 0, busy 0, done 0; state IDLE.
- Latency: from the accepting edge, done is high in the cycle after N = min(amount, WIDTH) further edges. Amount 0 gives done in the cycle right after the accepting edge, with out = in and carry = 0.
- Throughput: a new operation can be accepted on the edge that ends DONE, giving N+1 cycles per operation.
- out shows intermediate values while busy. It is valid only when done is high or after done.
- in, amount and mode are don't-care except on the accepting edge.

## Structure
- Package shift_pkg:
  - mode encoding: enum SHIFT_LSR, SHIFT_LSL, SHIFT_ASR, SHIFT_ROR.
  - FSM state enum: IDLE, SHIFT, DONE.
- Sub-module shift_step, purely combinational and parametrised by WIDTH:
  - inputs: word, mode.
  - outputs: next word, out-bit.
  - instantiated once inside seq_shifter.
- The FSM, counter and registers stay in seq_shifter.

## Test plan
All cases use WIDTH=16.
- LSR, in 0xB6F1, amount 1 -> done 2 edges after accept; out 0x5B78, carry 1.
- ASR, in 0x8001, amount 4 -> done 5 edges after accept; out 0xF800, carry 0; busy high for exactly 4 cycles.
- ROR, in 0x1234, amount 4 -> out 0x4123, carry 0. Then LSL, in 0x00FF, amount 20 -> clamped to 16; out 0x0000, carry 1; done 17 edges after accept.
- Second start pulse while busy (ROR 0x1234 by 4 running, new request LSL 0xFFFF by 1) -> ignored; result 0x4123 is unchanged. Back-to-back start in the DONE cycle -> accepted with no idle gap.
- clear asserted mid-shift, together with start -> next cycle: out 0, carry 0, busy 0, no done pulse.
- reset asserted between clock edges mid-shift -> out 0 and busy 0 before the next edge. After release, amount 0 with in 0xA5A5 -> done next cycle, out 0xA5A5, carry 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter: shift-mode encoding and FSM states.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    SHIFT_LSR = 2'b00,
    SHIFT_LSL = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Single-position shift of a word in one of four modes; purely combinational.
// bit_o is the bit that leaves the word on this step.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] word_i,
  input  shift_mode_e      mode_i,
  output logic [WIDTH-1:0] word_o,
  output logic             bit_o
);

  always_comb begin
    word_o = word_i;
    bit_o  = 1'b0;
    case (mode_i)
      SHIFT_LSR: begin
        word_o = {1'b0, word_i[WIDTH-1:1]};
        bit_o  = word_i[0];
      end
      SHIFT_LSL: begin
        word_o = {word_i[WIDTH-2:0], 1'b0};
        bit_o  = word_i[WIDTH-1];
      end
      SHIFT_ASR: begin
        word_o = {word_i[WIDTH-1], word_i[WIDTH-1:1]};
        bit_o  = word_i[0];
      end
      SHIFT_ROR: begin
        word_o = {word_i[0], word_i[WIDTH-1:1]};
        bit_o  = word_i[0];
      end
      default: begin
        word_o = word_i;
        bit_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-mode sequential shifter: one bit position per clock, amount clamped to WIDTH.
// done pulses one cycle after the last step; start is ignored while busy.
module seq_shifter
  import shift_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  shift_state_e     state_q, state_d;
  shift_mode_e      mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_word;
  logic             step_bit;
  logic [AMT_W-1:0] amt_clamped;
  logic             accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .word_i (out_q),
    .mode_i (mode_q),
    .word_o (step_word),
    .bit_o  (step_bit)
  );

  assign amt_clamped = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;
  assign accept      = start && (state_q != SHIFT);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    if (clear) begin
      state_d = IDLE;
      out_d   = '0;
      cnt_d   = '0;
      carry_d = 1'b0;
    end else if (accept) begin
      out_d   = in;
      mode_d  = shift_mode_e'(mode);
      cnt_d   = amt_clamped;
      carry_d = 1'b0;
      state_d = (amt_clamped == '0) ? DONE : SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          out_d   = step_word;
          carry_d = step_bit;
          cnt_d   = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // Flags are registered from the next state so they align exactly with it.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= SHIFT_LSR;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter (WIDTH=16): directed cases plus random operations against an arithmetic model.
module tb_seq_shifter;

  localparam int W  = 16;
  localparam int AW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          reset, clear, start;
  logic [W-1:0]  din;
  logic [AW-1:0] amount;
  logic [1:0]    mode;
  logic [W-1:0]  dout;
  logic          carry, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .start  (start),
    .in     (din),
    .amount (amount),
    .mode   (mode),
    .out    (dout),
    .carry  (carry),
    .busy   (busy),
    .done   (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-operation result from plain arithmetic on the original operand.
  function automatic void model(input logic [15:0] d, input int amt, input logic [1:0] md,
                                output logic [15:0] r, output logic c);
    int n;
    logic [31:0] x;
    logic signed [31:0] s;
    n = (amt > W) ? W : amt;
    x = {16'h0, d};
    s = {{16{d[15]}}, d};
    c = 1'b0;
    case (md)
      2'd0: begin r = 16'(x >> n); if (n > 0) c = d[n-1]; end
      2'd1: begin r = 16'(x << n); if (n > 0) c = d[W-n]; end
      2'd2: begin r = 16'(s >>> n); if (n > 0) c = d[n-1]; end
      default: begin r = 16'((x >> n) | (x << (W - n))); if (n > 0) c = d[n-1]; end
    endcase
  endfunction

  task automatic start_op(input logic [15:0] d, input int amt, input logic [1:0] md);
    start  = 1'b1;
    din    = d;
    amount = AW'(amt);
    mode   = md;
    @(posedge clk);
    #1;
    start  = 1'b0;
    din    = 16'($urandom);
    amount = AW'($urandom);
    mode   = 2'($urandom);
  endtask

  // skip = edges already consumed after the accepting edge before this is called.
  task automatic finish_op(input string tag, input logic [15:0] d, input int amt,
                           input logic [1:0] md, input int skip, input bit linger);
    logic [15:0] er;
    logic ec;
    int k, nb, n;
    k  = 0;
    nb = 0;
    n  = ((amt > W) ? W : amt) - skip;
    model(d, amt, md, er, ec);
    while (k < 40) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
      k++;
    end
    check_eq({tag, ".latency"}, k, n);
    check_eq({tag, ".busy_cycles"}, nb, n);
    check_eq({tag, ".out"}, dout, er);
    check_eq({tag, ".carry"}, carry, ec);
    if (linger) begin
      @(negedge clk);
      check_eq({tag, ".done_drop"}, done, 1'b0);
      check_eq({tag, ".out_hold"}, dout, er);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] d, input int amt, input logic [1:0] md);
    @(negedge clk);
    start_op(d, amt, md);
    finish_op(tag, d, amt, md, 0, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clear = 1'b0; start = 1'b0;
    din = '0; amount = '0; mode = '0;
    #3;
    check_eq("rst.out", dout, 0);
    check_eq("rst.carry", carry, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op("lsr1", 16'hB6F1, 1, 2'd0);
    run_op("asr4", 16'h8001, 4, 2'd2);
    run_op("ror4", 16'h1234, 4, 2'd3);
    run_op("lsl20", 16'h00FF, 20, 2'd1);
    run_op("asr16", 16'h8000, 16, 2'd2);
    run_op("ror16", 16'hBEEF, 16, 2'd3);

    // Start while busy must be ignored.
    @(negedge clk);
    start_op(16'h1234, 4, 2'd3);
    @(negedge clk);
    check_eq("ign.busy", busy, 1'b1);
    start = 1'b1; din = 16'hFFFF; amount = AW'(1); mode = 2'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_op("ign", 16'h1234, 4, 2'd3, 1, 1'b1);

    // Back-to-back: second start lands in the DONE cycle.
    @(negedge clk);
    start_op(16'hB6F1, 1, 2'd0);
    finish_op("b2b_a", 16'hB6F1, 1, 2'd0, 0, 1'b0);
    start_op(16'h8001, 4, 2'd2);
    finish_op("b2b_b", 16'h8001, 4, 2'd2, 0, 1'b1);

    // Clear mid-shift together with start.
    @(negedge clk);
    start_op(16'hFFFF, 10, 2'd0);
    repeat (3) @(negedge clk);
    clear = 1'b1; start = 1'b1; din = 16'h1111; amount = AW'(2); mode = 2'd0;
    @(posedge clk);
    #1;
    clear = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("clr.out", dout, 0);
    check_eq("clr.carry", carry, 0);
    check_eq("clr.busy", busy, 0);
    check_eq("clr.done", done, 0);
    @(negedge clk);
    check_eq("clr.done_later", done, 0);
    check_eq("clr.busy_later", busy, 0);

    // Asynchronous reset between edges mid-shift.
    @(negedge clk);
    start_op(16'h8001, 8, 2'd2);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("arst.out", dout, 0);
    check_eq("arst.busy", busy, 0);
    check_eq("arst.carry", carry, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op("arst_a0", 16'hA5A5, 0, 2'd0);

    for (int i = 0; i < 40; i++) begin
      int amt;
      amt = (i % 8 == 0) ? 16 : int'($urandom_range(0, 31));
      run_op("rnd", 16'($urandom), amt, 2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
